// File: rtl/triggered_averaging_accumulator.sv
// Triggered record averager: sums NUM_AVG triggered records sample-by-sample, then reads them out FWFT.
// Optional DATA_ACC_SATURATE_EN: clamp overflowing sums instead of wrapping.
module triggered_averaging_accumulator #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 18,
   parameter int RECORD_LEN = 256,
   parameter int NUM_AVG    = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] inputData,
   input  logic                  dataCaptureStrobe,
   input  logic                  dataRead,
   output logic                  dataReadyToRead,
   output logic                  dataEmpty,
   output logic [ACC_WIDTH-1:0]  dataOut,
   output logic                  armed,
   output logic                  overflow
);

   localparam int AW = (RECORD_LEN > 1) ? $clog2(RECORD_LEN) : 1;
   localparam int PW = $clog2(NUM_AVG + 1);

   localparam logic [1:0] S_ARMED   = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_READOUT = 2'd3;

   localparam logic [AW-1:0]        LAST_ADDR = AW'(RECORD_LEN - 1);
   localparam logic [PW-1:0]        LAST_PASS = PW'(NUM_AVG - 1);
   localparam logic [ACC_WIDTH-1:0] ACC_MAX   = '1;

   logic [1:0]           state_q, state_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [PW-1:0]        pass_q, pass_d;
   logic                 ready_q, ready_d;
   logic                 ovf_q, ovf_d;
   logic [ACC_WIDTH-1:0] dout_q, dout_d;
   logic                 we_q, we_d;

   // Accumulation RAM and its pipeline registers carry no reset.
   logic [ACC_WIDTH-1:0]  mem [RECORD_LEN];
   logic [ACC_WIDTH-1:0]  rd_q;
   logic [DATA_WIDTH-1:0] smp_q;
   logic [AW-1:0]         wa_q;
   logic                  first_q;

   logic [AW-1:0]        rd_addr;
   logic                 sample_en;
   logic [ACC_WIDTH:0]   sum;
   logic [ACC_WIDTH-1:0] smp_ext;
   logic [ACC_WIDTH-1:0] wdata;

   assign smp_ext = ACC_WIDTH'(smp_q);
   assign sum     = {1'b0, rd_q} + {1'b0, smp_ext};

   always_comb begin
      wdata = sum[ACC_WIDTH-1:0];
`ifdef DATA_ACC_SATURATE_EN
      if (sum[ACC_WIDTH]) wdata = ACC_MAX;
`endif
      if (first_q) wdata = smp_ext;
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pass_d    = pass_q;
      ready_d   = ready_q;
      dout_d    = dout_q;
      ovf_d     = ovf_q;
      sample_en = 1'b0;
      rd_addr   = addr_q;
      if (we_q && !first_q && sum[ACC_WIDTH]) ovf_d = 1'b1;
      case (state_q)
         S_ARMED: begin
            if (dataCaptureStrobe) begin
               sample_en = 1'b1;
               addr_d    = addr_q + AW'(1);
               state_d   = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            sample_en = 1'b1;
            addr_d    = addr_q + AW'(1);
            if (addr_q == LAST_ADDR) begin
               pass_d  = pass_q + PW'(1);
               state_d = (pass_q == LAST_PASS) ? S_DRAIN : S_ARMED;
            end
         end
         S_DRAIN: begin
            state_d = S_READOUT;
         end
         default: begin
            // rd_q always holds the word after the one presented on dataOut.
            rd_addr = addr_q + AW'(1);
            if (!ready_q) begin
               ready_d = 1'b1;
               dout_d  = rd_q;
            end else if (dataRead) begin
               if (addr_q == LAST_ADDR) begin
                  ready_d = 1'b0;
                  pass_d  = '0;
                  ovf_d   = 1'b0;
                  addr_d  = '0;
                  state_d = S_ARMED;
               end else begin
                  dout_d  = rd_q;
                  addr_d  = addr_q + AW'(1);
                  rd_addr = addr_q + AW'(2);
               end
            end
         end
      endcase
      we_d = sample_en;
   end

   always_ff @(posedge clk) begin
      rd_q <= mem[rd_addr];
      if (we_q) mem[wa_q] <= wdata;
      if (sample_en) begin
         smp_q   <= inputData;
         wa_q    <= addr_q;
         first_q <= (pass_q == '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_ARMED;
         addr_q  <= '0;
         pass_q  <= '0;
         ready_q <= 1'b0;
         ovf_q   <= 1'b0;
         dout_q  <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pass_q  <= pass_d;
         ready_q <= ready_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
         we_q    <= we_d;
      end
   end

   assign armed           = (state_q == S_ARMED);
   assign dataReadyToRead = ready_q;
   assign dataEmpty       = ~ready_q;
   assign dataOut         = dout_q;
   assign overflow        = ovf_q;

endmodule
